// File: rtl/alu_seq.sv
// 8-bit sequential ALU: single-cycle logic/arithmetic ops plus an 8-step
// shift-add unsigned multiplier, with registered result, flags and done pulse.
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   input  logic       start,
   output logic [7:0] dout,
   output logic [7:0] dout_hi,
   output logic       busy,
   output logic       done,
   output logic       zflag,
   output logic       cflag,
   output logic       nflag
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_INC = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [0:0]  state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [15:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  hi_q, hi_d;
   logic        z_q, z_d;
   logic        c_q, c_d;
   logic        n_q, n_d;
   logic        done_q, done_d;

   logic [7:0]  alu_res_s;
   logic        alu_c_s;
   logic [15:0] addend_s;
   logic [15:0] sum_s;

   // Single-cycle datapath for every opcode except MUL
   always_comb begin
      alu_res_s = 8'h00;
      alu_c_s   = 1'b0;
      case (op)
         OP_ADD:  {alu_c_s, alu_res_s} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            alu_res_s = a - b;
            alu_c_s   = (a < b);
         end
         OP_AND:  alu_res_s = a & b;
         OP_OR:   alu_res_s = a | b;
         OP_XOR:  alu_res_s = a ^ b;
         OP_NOT:  alu_res_s = ~a;
         OP_INC: begin
            alu_res_s = a + 8'd1;
            alu_c_s   = (a == 8'hFF);
         end
         default: begin
            alu_res_s = 8'h00;
            alu_c_s   = 1'b0;
         end
      endcase
   end

   // One shift-add step: add A shifted by the step index when that B bit is set
   always_comb begin
      if (b_q[cnt_q]) begin
         addend_s = {8'h00, a_q} << cnt_q;
      end else begin
         addend_s = 16'h0000;
      end
      sum_s = acc_q + addend_s;
   end

   // Next-state logic for the control FSM, operand latches and result registers
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      hi_d    = hi_q;
      z_d     = z_q;
      c_d     = c_q;
      n_d     = n_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  a_d     = a;
                  b_d     = b;
                  acc_d   = 16'h0000;
                  cnt_d   = 3'd0;
                  state_d = ST_MUL;
               end else begin
                  dout_d = alu_res_s;
                  hi_d   = 8'h00;
                  z_d    = (alu_res_s == 8'h00);
                  c_d    = alu_c_s;
                  n_d    = alu_res_s[7];
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            // start is deliberately ignored here; operands come from the latches
            acc_d = sum_s;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               dout_d  = sum_s[7:0];
               hi_d    = sum_s[15:8];
               z_d     = (sum_s == 16'h0000);
               c_d     = (sum_s[15:8] != 8'h00);
               n_d     = sum_s[15];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MUL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         acc_q   <= 16'h0000;
         cnt_q   <= 3'd0;
         dout_q  <= 8'h00;
         hi_q    <= 8'h00;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         hi_q    <= hi_d;
         z_q     <= z_d;
         c_q     <= c_d;
         n_q     <= n_d;
         done_q  <= done_d;
      end
   end

   assign dout    = dout_q;
   assign dout_hi = hi_q;
   assign busy    = (state_q == ST_MUL);
   assign done    = done_q;
   assign zflag   = z_q;
   assign cflag   = c_q;
   assign nflag   = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_alu_seq;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       start;
   logic [7:0] dout;
   logic [7:0] dout_hi;
   logic       busy;
   logic       done;
   logic       zflag;
   logic       cflag;
   logic       nflag;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] h;
      logic       z;
      logic       c;
      logic       n;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   alu_seq dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .op      (op),
      .start   (start),
      .dout    (dout),
      .dout_hi (dout_hi),
      .busy    (busy),
      .done    (done),
      .zflag   (zflag),
      .cflag   (cflag),
      .nflag   (nflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: dout=%h dout_hi=%h with no operation pending", dout, dout_hi);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({dout, dout_hi, zflag, cflag, nflag} !== e) begin
               errors++;
               $display("FAIL result: got dout=%h hi=%h z=%b c=%b n=%b, expected dout=%h hi=%h z=%b c=%b n=%b",
                        dout, dout_hi, zflag, cflag, nflag, e.d, e.h, e.z, e.c, e.n);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Drive one start at the current negedge; returns at the following negedge
   task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic push, input logic [7:0] ed, input logic [7:0] eh,
                        input logic ez, input logic ec, input logic en);
      op    = o;
      a     = av;
      b     = bv;
      start = 1'b1;
      if (push) exp_q.push_back({ed, eh, ez, ec, en});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      op    = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", {8'h0, dout, dout_hi, busy, done, zflag, cflag, nflag, 3'b0}, 32'h0);

      // ADD with carry; done exactly one cycle after the start edge
      issue(3'b000, 8'hF0, 8'h20, 1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("add_done_high", {31'h0, done}, 32'h1);
      @(negedge clk);
      chk("add_done_low", {31'h0, done}, 32'h0);

      issue(3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      issue(3'b001, 8'h03, 8'h05, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b1);
      issue(3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
      issue(3'b011, 8'h0F, 8'hF0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
      issue(3'b100, 8'hAA, 8'hAA, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      // Back-to-back: second start lands in the done cycle of the first
      issue(3'b000, 8'h01, 8'h02, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
      issue(3'b110, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);

      // MUL FF*FF = FE01, busy for exactly 8 cycles
      issue(3'b111, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1);
      wait_idle(n);
      chk("mul_busy_cycles", n, 32'd8);
      chk("mul_done_after_busy", {31'h0, done}, 32'h1);
      // Start in the MUL done cycle is accepted
      issue(3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

      // MUL 03*04 with operands, op and start disturbed in cycle 3
      issue(3'b111, 8'h03, 8'h04, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      op    = 3'b000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      repeat (4) @(negedge clk);

      // Reset during the 4th MUL cycle aborts it silently
      issue(3'b111, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs", {8'h0, dout, dout_hi, busy, done, zflag, cflag, nflag, 3'b0}, 32'h0);
      repeat (10) @(negedge clk);
      chk("abort_stays_idle", {31'h0, busy}, 32'h0);

      issue(3'b110, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      // MUL 10*10 = 0100: low byte zero but full product nonzero
      issue(3'b111, 8'h10, 8'h10, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
      wait_idle(n);
      chk("mul2_busy_cycles", n, 32'd8);

      // NOT clears dout_hi; results then hold while inputs wander
      issue(3'b101, 8'h0F, 8'h00, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         a  = 8'h5A + 8'(i);
         b  = 8'hC3;
         op = 3'(i);
         @(negedge clk);
         chk("hold_outputs", {13'h0, dout, dout_hi, zflag, cflag, nflag}, {13'h0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1});
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
